// File: rtl/ev20_call_stack.sv
// Return-address stack for the EV20 core: pushes PC+1 on call, pops on return,
// and drives a one-cycle preload of the PC counter with the new address.
module ev20_call_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 11,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          res,
  input  logic [AW-1:0] pc,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] call_target,
  input  logic          clr_err,
  output logic [AW-1:0] pc_load,
  output logic          preload,
  output logic [PW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf,
  output logic          err
);

  // Request semantics: call/ret are single-cycle requests sampled on each rising
  // edge. There is no ready; a request that arrives while preload is high is
  // dropped without effect, since the instruction that issued it is stale.

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_m1;
  logic          live;
  logic          do_call;
  logic          do_ret;
  logic          ovf_ev;
  logic          unf_ev;
  logic          err_ev;

  assign sp_m1   = sp - PW'(1);
  assign live    = !preload;
  assign do_call = live &&  call && !ret && !full;
  assign do_ret  = live && !call &&  ret && !empty;
  assign ovf_ev  = live &&  call && !ret &&  full;
  assign unf_ev  = live && !call &&  ret &&  empty;
  assign err_ev  = live &&  call &&  ret;

  assign depth = sp;
  assign empty = (sp == '0);
  assign full  = (sp == PW'(DEPTH));

  // Storage carries no reset; contents past sp are never observed.
  always_ff @(posedge clk) begin
    if (do_call) mem[sp[PW-2:0]] <= pc + AW'(1);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sp      <= '0;
      preload <= 1'b0;
      pc_load <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      preload <= do_call || do_ret;
      if (do_call) begin
        sp      <= sp + PW'(1);
        pc_load <= call_target;
      end else if (do_ret) begin
        sp      <= sp_m1;
        pc_load <= mem[sp_m1[PW-2:0]];
      end
      // A new event in the same cycle as clr_err leaves the flag set.
      ovf <= ovf_ev || (ovf && !clr_err);
      unf <= unf_ev || (unf && !clr_err);
      err <= err_ev || (err && !clr_err);
    end
  end

endmodule

// File: tb/tb_ev20_call_stack.sv
// Directed bench for ev20_call_stack (DEPTH=8, AW=11) with hand-computed
// expectations checked by immediate assertions.
module tb_ev20_call_stack;

  logic        clk;
  logic        res;
  logic [10:0] pc;
  logic        call;
  logic        ret;
  logic [10:0] call_target;
  logic        clr_err;
  logic [10:0] pc_load;
  logic        preload;
  logic [3:0]  depth;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        unf;
  logic        err;

  int total = 0;
  int bad   = 0;

  ev20_call_stack #(.DEPTH(8), .AW(11)) dut (
    .clk(clk), .res(res), .pc(pc), .call(call), .ret(ret),
    .call_target(call_target), .clr_err(clr_err), .pc_load(pc_load),
    .preload(preload), .depth(depth), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf), .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e_ovf, input logic e_unf, input logic e_err);
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, "_unf"}, 32'(unf), 32'(e_unf));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
  endtask

  initial begin
    res = 1'b0; pc = '0; call = 1'b0; ret = 1'b0; call_target = '0; clr_err = 1'b0;
    repeat (2) cyc();

    // reset state
    chk("rst_depth",   32'(depth),   0);
    chk("rst_empty",   32'(empty),   1);
    chk("rst_full",    32'(full),    0);
    chk("rst_preload", 32'(preload), 0);
    chk("rst_pc_load", 32'(pc_load), 0);
    chk_flags("rst", 0, 0, 0);
    res = 1'b1;
    cyc();
    chk("idle_preload", 32'(preload), 0);
    chk("idle_depth",   32'(depth),   0);

    // call / return round trip
    pc = 11'h010; call_target = 11'h200; call = 1'b1;
    cyc();
    chk("call_preload", 32'(preload), 1);
    chk("call_pc_load", 32'(pc_load), 11'h200);
    chk("call_depth",   32'(depth),   1);
    call = 1'b0;
    cyc();
    chk("call_pulse_end", 32'(preload), 0);
    chk("call_hold",      32'(pc_load), 11'h200);
    ret = 1'b1;
    cyc();
    chk("ret_preload", 32'(preload), 1);
    chk("ret_pc_load", 32'(pc_load), 11'h011);
    chk("ret_depth",   32'(depth),   0);
    chk("ret_empty",   32'(empty),   1);
    ret = 1'b0;
    cyc();

    // nest to full
    for (int i = 0; i < 8; i++) begin
      pc = 11'(11'h100 + i); call_target = 11'(11'h400 + i); call = 1'b1;
      cyc();
      chk("nest_preload", 32'(preload), 1);
      chk("nest_depth",   32'(depth),   32'(i + 1));
      call = 1'b0;
      cyc();
    end
    chk("nest_full",  32'(full),  1);
    chk("nest_empty", 32'(empty), 0);
    pc = 11'h1F0; call = 1'b1;
    cyc();
    chk("ovf_preload", 32'(preload), 0);
    chk("ovf_depth",   32'(depth),   8);
    chk_flags("ovf", 1, 0, 0);
    call = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      ret = 1'b1;
      cyc();
      chk("unwind_preload", 32'(preload), 1);
      chk("unwind_pc_load", 32'(pc_load), 32'(11'h108 - i));
      chk("unwind_depth",   32'(depth),   32'(7 - i));
      ret = 1'b0;
      cyc();
    end
    chk("unwind_empty", 32'(empty), 1);

    // underflow, clear
    ret = 1'b1;
    cyc();
    chk("unf_preload", 32'(preload), 0);
    chk("unf_depth",   32'(depth),   0);
    chk_flags("unf", 1, 1, 0);
    ret = 1'b0; clr_err = 1'b1;
    cyc();
    chk_flags("clr", 0, 0, 0);
    // new event beats clr_err in the same cycle
    ret = 1'b1;
    cyc();
    chk_flags("clr_race", 0, 1, 0);
    ret = 1'b0;
    cyc();
    chk_flags("clr2", 0, 0, 0);
    clr_err = 1'b0;

    // simultaneous requests
    pc = 11'h050; call_target = 11'h123; call = 1'b1; ret = 1'b1;
    cyc();
    chk("both_preload", 32'(preload), 0);
    chk("both_depth",   32'(depth),   0);
    chk("both_pc_load", 32'(pc_load), 11'h101);
    chk_flags("both", 0, 0, 1);
    call = 1'b0; ret = 1'b0; clr_err = 1'b1;
    cyc();
    chk_flags("both_clr", 0, 0, 0);
    clr_err = 1'b0;

    // flush: ret in the preload cycle is ignored
    pc = 11'h020; call_target = 11'h300; call = 1'b1;
    cyc();
    chk("flush_call_preload", 32'(preload), 1);
    call = 1'b0; ret = 1'b1;
    cyc();
    chk("flush_preload", 32'(preload), 0);
    chk("flush_depth",   32'(depth),   1);
    chk("flush_pc_load", 32'(pc_load), 11'h300);
    chk_flags("flush", 0, 0, 0);
    ret = 1'b0;

    // wrap-around with immediate return (bypass)
    pc = 11'h7FF; call_target = 11'h050; call = 1'b1;
    cyc();
    chk("wrap_depth", 32'(depth), 2);
    call = 1'b0;
    cyc();
    ret = 1'b1;
    cyc();
    chk("wrap_pc_load", 32'(pc_load), 11'h000);
    chk("wrap_depth1",  32'(depth),   1);
    ret = 1'b0;
    cyc();
    ret = 1'b1;
    cyc();
    chk("pop_old_pc_load", 32'(pc_load), 11'h021);
    chk("pop_old_empty",   32'(empty),   1);
    ret = 1'b0;
    cyc();

    // async reset mid-pulse
    pc = 11'h030; call_target = 11'h400; call = 1'b1;
    cyc();
    chk("arst_pre_preload", 32'(preload), 1);
    call = 1'b0;
    #2 res = 1'b0;
    #1;
    chk("arst_preload", 32'(preload), 0);
    chk("arst_depth",   32'(depth),   0);
    chk("arst_pc_load", 32'(pc_load), 0);
    chk("arst_empty",   32'(empty),   1);
    @(negedge clk);
    res = 1'b1;
    cyc();
    chk("post_rst_preload", 32'(preload), 0);
    chk("post_rst_depth",   32'(depth),   0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ev20_call_stack.md
# ev20_call_stack

Hardware call/return stack for the EV20 core, at the opposite end of the program counter's preload interface. It samples the current PC, and on a call pushes the return address and drives a one-cycle preload of the call target; on a return it pops the saved address and drives the preload with it. Its `pc_load`/`preload` outputs connect directly to the PC counter's `in`/`preload` inputs, and its `pc` input is fed from the counter's `new_PC`.

## Interface
- `DEPTH`, 8 — number of return-address entries; power of two, 2..64.
- `AW`, 11 — address width; must match the PC width.

- `clk`  in  1  — clock; all state updates on the rising edge.
- `res`  in  1  — asynchronous, active-low reset.
- `pc`  in  AW  — current PC from the PC counter.
- `call`  in  1  — call request, sampled on the rising edge.
- `ret`  in  1  — return request, sampled on the rising edge.
- `call_target`  in  AW  — jump target for `call`.
- `clr_err`  in  1  — synchronous clear of the sticky error flags.
- `pc_load`  out  AW  — address driven to the PC counter's preload input.
- `preload`  out  1  — one-cycle preload strobe to the PC counter.
- `depth`  out  log2(DEPTH)+1  — number of valid entries.
- `empty`  out  1  — `depth == 0`.
- `full`  out  1  — `depth == DEPTH`.
- `ovf`  out  1  — sticky flag: a call was refused because the stack was full.
- `unf`  out  1  — sticky flag: a return was refused because the stack was empty.
- `err`  out  1  — sticky flag: `call` and `ret` were asserted in the same cycle.

## Operation
- Storage: `DEPTH` × `AW` register array and a pointer `sp` (= `depth`). Push writes `mem[sp]` then increments `sp`; pop reads `mem[sp-1]` then decrements `sp`.
- Accepted call (`call=1`, `ret=0`, `!full`, `preload=0`):
  - push `(pc + 1) mod 2^AW`; `pc` = 2047 pushes 0;
  - `pc_load <= call_target`, `preload <= 1`.
- Accepted return (`ret=1`, `call=0`, `!empty`, `preload=0`):
  - `pc_load <= mem[sp-1]`, `sp <= sp-1`, `preload <= 1`.
- Call while full: no push, no preload, `ovf <= 1`.
- Return while empty: no pop, no preload, `unf <= 1`.
- `call` and `ret` both high: neither is performed, `err <= 1`.
- Flush rule: any request in a cycle where `preload == 1` is discarded silently. No state change and no flag change, because that instruction is already stale.
- `preload` is high for exactly one cycle per accepted operation; otherwise it is 0.
- `pc_load` holds its last value when `preload` is 0.
- `clr_err`: `ovf`, `unf` and `err` are cleared to 0 at the next edge. A new error event in the same cycle wins: the flag ends up 1.
- `depth`, `empty` and `full` are registered and reflect `sp` after the edge.

## Timing
- Reset (`res=0`, asynchronous, held):
  - `sp=0`, `depth=0`, `empty=1`, `full=0`;
  - `preload=0`, `pc_load=0`, `ovf=unf=err=0`.
  - Memory contents are don't-care.
  - Reset during any operation abandons it, including a pending preload.
- Latency: request sampled at edge k, then `preload`/`pc_load` valid after edge k. The PC counter loads at edge k+1, so `new_PC == target` after edge k+1.
- Back-to-back: the earliest next accepted request is sampled at edge k+2. A request sampled at edge k+1 is flushed.
- Bypass: a return issued immediately after a call (first non-flushed cycle) returns the just-pushed address.
- `depth` only takes values 0..DEPTH and never wraps.

## Test plan
- Reset then idle:
  - Response: `depth=0`, `empty=1`, `preload=0`, `pc_load=0`, all flags 0.
- Call/return round trip:
  - Stimulus: `pc=0x010`, `call`, `call_target=0x200`.
  - Response: `preload` pulses one cycle with `pc_load=0x200`; `depth=1`.
  - Stimulus: `ret` two cycles later.
  - Response: `pc_load=0x011`, `depth=0`, `empty=1`.
- Nesting to full with DEPTH=8:
  - Stimulus: 8 calls at `pc=0x100+i`.
  - Response: `full=1`.
  - Stimulus: a ninth call.
  - Response: no preload, `ovf=1`.
  - Stimulus: 8 returns.
  - Response: returned addresses are `0x108` down to `0x101`.
- Underflow and clear:
  - Stimulus: `ret` while empty.
  - Response: `unf=1`, no preload.
  - Stimulus: `clr_err`.
  - Response: `unf=0`.
- Simultaneous requests and flush:
  - Stimulus: `call` and `ret` together.
  - Response: `err=1`, no state change.
  - Stimulus: a call, then a `ret` in the cycle where `preload=1`.
  - Response: the `ret` is ignored and `depth` stays 1.
- Wrap-around and async reset:
  - Stimulus: call at `pc=0x7FF`, then ret.
  - Response: `pc_load=0x000`.
  - Stimulus: assert `res` mid-pulse.
  - Response: `preload` drops immediately and `depth=0`.
